// File: rtl/params_pkg.sv
// params_pkg: shared types and constants for the page-table walker.
//   PADDR_WIDTH   - default physical address width
//   PTE_PPN_LSB   - bit position of the PPN field inside a PTE
//   ptw_state_e   - walker FSM states
//   ptw_fault_e   - page-fault cause encoding driven on fault_cause_o
//   pte_t         - PTE field layout for the default two-level geometry
package params_pkg;

  localparam int PADDR_WIDTH   = 32;
  localparam int PTE_PPN_LSB   = 10;
  localparam int PTE_PPN_W_DEF = 20;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MEM_REQ  = 3'd1,
    MEM_WAIT = 3'd2,
    DONE     = 3'd3,
    DRAIN    = 3'd4
  } ptw_state_e;

  typedef enum logic [1:0] {
    FAULT_INVALID    = 2'd0,
    FAULT_W_NO_R     = 2'd1,
    FAULT_NONLEAF_L0 = 2'd2,
    FAULT_MISALIGNED = 2'd3
  } ptw_fault_e;

  // Bits [9:4] (RSW/D/A/G/U) are not interpreted by the walker.
  typedef struct packed {
    logic [31-PTE_PPN_LSB-PTE_PPN_W_DEF:0] rsvd;
    logic [PTE_PPN_W_DEF-1:0]              ppn;
    logic [5:0]                            ign;
    logic                                  x;
    logic                                  w;
    logic                                  r;
    logic                                  v;
  } pte_t;

endpackage

// File: rtl/pte_decode.sv
// pte_decode: combinational PTE classifier for one walk step.
//   pte_i    - raw PTE word from memory
//   level_i  - level the PTE was fetched at
//   leaf_o   - valid, aligned leaf; translation completes
//   next_o   - valid pointer to the next level
//   fault_o  - page fault, reason on cause_o
//   cause_o  - fault cause (meaningful only with fault_o)
//   ppn_o    - PPN field of the PTE
module pte_decode
  import params_pkg::*;
#(
  parameter int  LEVELS     = 2,
  parameter int  VPN_BITS   = 10,
  parameter int  DATA_WIDTH = 32,
  localparam int PPN_W      = LEVELS * VPN_BITS,
  localparam int LVL_W      = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
  input  logic [DATA_WIDTH-1:0] pte_i,
  input  logic [LVL_W-1:0]      level_i,
  output logic                  leaf_o,
  output logic                  next_o,
  output logic                  fault_o,
  output ptw_fault_e            cause_o,
  output logic [PPN_W-1:0]      ppn_o
);

  logic             v, r, w, x;
  logic [PPN_W-1:0] align_mask;
  logic             unused_pte;

  assign v     = pte_i[0];
  assign r     = pte_i[1];
  assign w     = pte_i[2];
  assign x     = pte_i[3];
  assign ppn_o = pte_i[PTE_PPN_LSB +: PPN_W];

  // A superpage leaf at level L must have its low L*VPN_BITS PPN bits clear.
  assign align_mask = PPN_W'((64'd1 << (level_i * VPN_BITS)) - 64'd1);

  assign unused_pte = ^pte_i;

  always_comb begin
    leaf_o  = 1'b0;
    next_o  = 1'b0;
    fault_o = 1'b0;
    cause_o = FAULT_INVALID;
    if (!v) begin
      fault_o = 1'b1;
      cause_o = FAULT_INVALID;
    end else if (w && !r) begin
      fault_o = 1'b1;
      cause_o = FAULT_W_NO_R;
    end else if (r || x) begin
      if ((ppn_o & align_mask) != '0) begin
        fault_o = 1'b1;
        cause_o = FAULT_MISALIGNED;
      end else begin
        leaf_o = 1'b1;
      end
    end else if (level_i == '0) begin
      fault_o = 1'b1;
      cause_o = FAULT_NONLEAF_L0;
    end else begin
      next_o = 1'b1;
    end
  end

endmodule

// File: rtl/ptw_walker.sv
// ptw_walker: multi-level page-table walker.
//   clk_i, rst_i            - clock, synchronous active-high reset
//   req_valid_i/req_ready_o - translation request / walker idle
//   vaddr_i, satp_data_i    - virtual address and root PPN, sampled on accept
//   flush_i                 - abort the walk in progress
//   mem_req_o/mem_addr_o    - PTE read request and address
//   mem_gnt_i               - read request accepted
//   mem_valid_i/mem_data_i  - PTE read data
//   valid_o/error_o         - one-cycle completion / page-fault pulse
//   fault_cause_o, paddr_o  - fault cause and translated address
//
// state    | meaning
// IDLE     | ready for a request
// MEM_REQ  | PTE read requested, waiting for grant
// MEM_WAIT | granted, waiting for PTE data
// DONE     | result pulse cycle
// DRAIN    | flushed with a read outstanding, discard its data
module ptw_walker
  import params_pkg::*;
#(
  parameter int  LEVELS      = 2,
  parameter int  VPN_BITS    = 10,
  parameter int  PAGE_OFFSET = 12,
  parameter int  DATA_WIDTH  = 32,
  parameter int  PADDR_WIDTH = params_pkg::PADDR_WIDTH,
  localparam int PPN_W       = LEVELS * VPN_BITS,
  localparam int VADDR_W     = PAGE_OFFSET + PPN_W,
  localparam int LVL_W       = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [VADDR_W-1:0]     vaddr_i,
  input  logic [DATA_WIDTH-1:0]  satp_data_i,
  input  logic                   flush_i,
  output logic                   mem_req_o,
  output logic [PADDR_WIDTH-1:0] mem_addr_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_valid_i,
  input  logic [DATA_WIDTH-1:0]  mem_data_i,
  output logic                   valid_o,
  output logic                   error_o,
  output logic [1:0]             fault_cause_o,
  output logic [PADDR_WIDTH-1:0] paddr_o
);

  ptw_state_e             state_q, state_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic [VADDR_W-1:0]     vaddr_q, vaddr_d;
  logic [PPN_W-1:0]       ppn_q, ppn_d;
  logic [PADDR_WIDTH-1:0] paddr_q, paddr_d;
  ptw_fault_e             cause_q, cause_d;
  logic                   ok_q, ok_d;

  logic                   dec_leaf, dec_next, dec_fault;
  ptw_fault_e             dec_cause;
  logic [PPN_W-1:0]       dec_ppn;

  logic [VPN_BITS-1:0]    vpn_sel;
  logic [VADDR_W-1:0]     pte_addr;
  logic [VADDR_W-1:0]     low_mask;
  logic [VADDR_W-1:0]     leaf_addr;
  logic                   unused_satp;

  pte_decode #(
    .LEVELS    (LEVELS),
    .VPN_BITS  (VPN_BITS),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pte_decode (
    .pte_i  (mem_data_i),
    .level_i(level_q),
    .leaf_o (dec_leaf),
    .next_o (dec_next),
    .fault_o(dec_fault),
    .cause_o(dec_cause),
    .ppn_o  (dec_ppn)
  );

  assign vpn_sel  = VPN_BITS'(vaddr_q >> (PAGE_OFFSET + level_q * VPN_BITS));
  assign pte_addr = {ppn_q, {PAGE_OFFSET{1'b0}}} + VADDR_W'({vpn_sel, 2'b00});

  // Bits below the current level (lower VPNs + offset) pass through from vaddr.
  assign low_mask  = VADDR_W'((64'd1 << (PAGE_OFFSET + level_q * VPN_BITS)) - 64'd1);
  assign leaf_addr = ({dec_ppn, {PAGE_OFFSET{1'b0}}} & ~low_mask) | (vaddr_q & low_mask);

  assign unused_satp = ^satp_data_i;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    vaddr_d = vaddr_q;
    ppn_d   = ppn_q;
    paddr_d = paddr_q;
    cause_d = cause_q;
    ok_d    = ok_q;
    case (state_q)
      IDLE: begin
        if (!flush_i && req_valid_i) begin
          vaddr_d = vaddr_i;
          ppn_d   = satp_data_i[PPN_W-1:0];
          level_d = LVL_W'(LEVELS - 1);
          state_d = MEM_REQ;
        end
      end
      MEM_REQ: begin
        if (flush_i) begin
          state_d = mem_gnt_i ? DRAIN : IDLE;
        end else if (mem_gnt_i) begin
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (flush_i) begin
          // Data arriving with the flush is the outstanding read; nothing to drain.
          state_d = mem_valid_i ? IDLE : DRAIN;
        end else if (mem_valid_i) begin
          if (dec_next) begin
            ppn_d   = dec_ppn;
            level_d = level_q - LVL_W'(1);
            state_d = MEM_REQ;
          end else begin
            state_d = DONE;
            if (dec_fault) begin
              ok_d    = 1'b0;
              cause_d = dec_cause;
            end else begin
              ok_d    = dec_leaf;
              paddr_d = PADDR_WIDTH'(leaf_addr);
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      DRAIN: begin
        if (mem_valid_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      level_q <= '0;
      vaddr_q <= '0;
      ppn_q   <= '0;
      paddr_q <= '0;
      cause_q <= FAULT_INVALID;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      vaddr_q <= vaddr_d;
      ppn_q   <= ppn_d;
      paddr_q <= paddr_d;
      cause_q <= cause_d;
      ok_q    <= ok_d;
    end
  end

  assign req_ready_o   = (state_q == IDLE);
  assign mem_req_o     = (state_q == MEM_REQ);
  assign mem_addr_o    = mem_req_o ? PADDR_WIDTH'(pte_addr) : '0;
  assign valid_o       = (state_q == DONE) && ok_q && !flush_i;
  assign error_o       = (state_q == DONE) && !ok_q && !flush_i;
  assign fault_cause_o = cause_q;
  assign paddr_o       = paddr_q;

endmodule
